// File: rtl/rapcores_cmd_pkg.sv
// Shared command codes, version, FSM states and STATUS field layout for the SPI move sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rapcores_cmd_pkg;

  // Command header bytes (word_data[63:56])
  localparam logic [7:0] CMD_COORDINATED_STEP = 8'h01;
  localparam logic [7:0] CMD_MOTOR_ENABLE     = 8'h0A;
  localparam logic [7:0] CMD_CLK_DIVISOR      = 8'h0B;
  localparam logic [7:0] CMD_STATUS           = 8'h0C;
  localparam logic [7:0] CMD_API_VERSION      = 8'hFE;

  localparam logic [7:0] VERSION_MAJOR = 8'd0;
  localparam logic [7:0] VERSION_MINOR = 8'd3;
  localparam logic [7:0] VERSION_PATCH = 8'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MV_DUR,
    ST_MV_INC,
    ST_MV_INCINC,
    ST_VERSION,
    ST_DRAIN
  } state_t;

  // Move buffer write field select
  localparam logic [1:0] FLD_DIR    = 2'd0;
  localparam logic [1:0] FLD_DUR    = 2'd1;
  localparam logic [1:0] FLD_INC    = 2'd2;
  localparam logic [1:0] FLD_INCINC = 2'd3;

  // STATUS reply layout, LSB first: write index byte, occupancy byte, dtr bit, overflow bit
  localparam int STAT_WIND_LSB = 0;
  localparam int STAT_OCC_LSB  = 8;
  localparam int STAT_DTR_BIT  = 16;
  localparam int STAT_OVF_BIT  = 17;

endpackage

// File: rtl/move_buffer.sv
// Ring of move slots: per-slot duration, per-axis increment/incrementincrement, dir; occupancy tracking.
// Latency: writes and commit toggles land 1 cycle after the write strobe; reads and occupancy are combinational.
// Backpressure: none here; buffer_dtr/slot_busy tell the sequencer whether the write slot is free.
module move_buffer
  import rapcores_cmd_pkg::*;
#(
  parameter int NUM_AXES         = 1,
  parameter int MOVE_BUFFER_BITS = 2
) (
  input  logic                            CLK,
  input  logic                            resetn,
  input  logic                            wr_en,
  input  logic [MOVE_BUFFER_BITS-1:0]     wr_slot,
  input  logic [1:0]                      wr_field,
  input  logic [2:0]                      wr_ax,
  input  logic [63:0]                     wr_data,
  input  logic                            commit,
  input  logic [(1<<MOVE_BUFFER_BITS)-1:0] stepfinished,
  output logic [(1<<MOVE_BUFFER_BITS)-1:0] stepready,
  input  logic [MOVE_BUFFER_BITS-1:0]     rd_ind,
  output logic [63:0]                     move_duration,
  output logic [64*NUM_AXES-1:0]          increment,
  output logic [64*NUM_AXES-1:0]          incrementincrement,
  output logic [NUM_AXES-1:0]             dir,
  output logic                            slot_busy,
  output logic                            buffer_dtr,
  output logic [MOVE_BUFFER_BITS:0]       occ_cnt
);

  localparam int DEPTH = 1 << MOVE_BUFFER_BITS;

  logic [63:0]            dur_mem [DEPTH];
  logic [64*NUM_AXES-1:0] inc_mem [DEPTH];
  logic [64*NUM_AXES-1:0] ii_mem  [DEPTH];
  logic [NUM_AXES-1:0]    dir_mem [DEPTH];
  logic [DEPTH-1:0]       occ;

  assign occ                = stepready ^ stepfinished;
  assign slot_busy          = occ[wr_slot];
  assign buffer_dtr         = ~(&occ);
  assign move_duration      = dur_mem[rd_ind];
  assign increment          = inc_mem[rd_ind];
  assign incrementincrement = ii_mem[rd_ind];
  assign dir                = dir_mem[rd_ind];

  // Count occupied slots for the STATUS reply
  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_cnt = occ_cnt + (MOVE_BUFFER_BITS+1)'(occ[i]);
    end
  end

  // Slot storage writes and commit toggles; a slot only becomes visible to the DDA on commit
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      stepready <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dur_mem[i] <= '0;
        inc_mem[i] <= '0;
        ii_mem[i]  <= '0;
        dir_mem[i] <= '0;
      end
    end else begin
      if (commit) begin
        stepready[wr_slot] <= ~stepready[wr_slot];
      end
      if (wr_en) begin
        case (wr_field)
          FLD_DIR: dir_mem[wr_slot] <= wr_data[NUM_AXES-1:0];
          FLD_DUR: dur_mem[wr_slot] <= wr_data;
          FLD_INC: inc_mem[wr_slot][int'(wr_ax)*64 +: 64] <= wr_data;
          default: ii_mem[wr_slot][int'(wr_ax)*64 +: 64] <= wr_data;
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_move_sequencer.sv
// Decodes 64-bit SPI command words into multi-axis moves in a ring buffer; optional CMD_TIMEOUT_EN inter-word timeout.
// Latency: state, storage and replies update 1 cycle after each word_received strobe.
// Backpressure: none on the word stream; moves arriving while the write slot is full are dropped and flagged.
module spi_move_sequencer
  import rapcores_cmd_pkg::*;
#(
  parameter int NUM_AXES         = 1,
  parameter int MOVE_BUFFER_BITS = 2,
  parameter int CLK_DIV_RESET    = 40,
  parameter int TIMEOUT_CYCLES   = 1_600_000
) (
  input  logic                             CLK,
  input  logic                             resetn,
  input  logic                             word_received,
  input  logic [63:0]                      word_data,
  output logic [63:0]                      word_send_data,
  input  logic [(1<<MOVE_BUFFER_BITS)-1:0] stepfinished,
  output logic [(1<<MOVE_BUFFER_BITS)-1:0] stepready,
  output logic [MOVE_BUFFER_BITS-1:0]      writemoveind,
  output logic [63:0]                      move_duration,
  input  logic [MOVE_BUFFER_BITS-1:0]      rd_ind,
  output logic [64*NUM_AXES-1:0]           increment,
  output logic [64*NUM_AXES-1:0]           incrementincrement,
  output logic [NUM_AXES-1:0]              dir,
  input  logic [64*NUM_AXES-1:0]           encoder_count,
  output logic [NUM_AXES-1:0]              enable,
  output logic [7:0]                       clock_divisor,
  output logic                             buffer_dtr,
  output logic                             overflow
);

  localparam logic [2:0] LAST_AX = 3'(NUM_AXES - 1);

  state_t                    state;
  logic [2:0]                ax;
  logic                      drop;
  logic [64*NUM_AXES-1:0]    snap;
  logic                      wr_en;
  logic [1:0]                wr_field;
  logic                      commit;
  logic                      slot_busy;
  logic [MOVE_BUFFER_BITS:0] occ_cnt;
  logic [63:0]               status_word;
  logic [7:0]                hdr;

  assign hdr = word_data[63:56];

  move_buffer #(
    .NUM_AXES         (NUM_AXES),
    .MOVE_BUFFER_BITS (MOVE_BUFFER_BITS)
  ) u_buf (
    .CLK                (CLK),
    .resetn             (resetn),
    .wr_en              (wr_en),
    .wr_slot            (writemoveind),
    .wr_field           (wr_field),
    .wr_ax              (ax),
    .wr_data            (word_data),
    .commit             (commit),
    .stepfinished       (stepfinished),
    .stepready          (stepready),
    .rd_ind             (rd_ind),
    .move_duration      (move_duration),
    .increment          (increment),
    .incrementincrement (incrementincrement),
    .dir                (dir),
    .slot_busy          (slot_busy),
    .buffer_dtr         (buffer_dtr),
    .occ_cnt            (occ_cnt)
  );

  // Buffer write/commit decode: nothing is written for a dropped move
  always_comb begin
    wr_en    = 1'b0;
    wr_field = FLD_DUR;
    commit   = 1'b0;
    if (word_received) begin
      case (state)
        ST_IDLE: begin
          if (hdr == CMD_COORDINATED_STEP && !slot_busy) begin
            wr_en    = 1'b1;
            wr_field = FLD_DIR;
          end
        end
        ST_MV_DUR: begin
          wr_en    = !drop;
          wr_field = FLD_DUR;
        end
        ST_MV_INC: begin
          wr_en    = !drop;
          wr_field = FLD_INC;
        end
        ST_MV_INCINC: begin
          wr_en    = !drop;
          wr_field = FLD_INCINC;
          commit   = !drop && (ax == LAST_AX);
        end
        default: ;
      endcase
    end
  end

  // STATUS reply assembled from live buffer state
  always_comb begin
    status_word                     = '0;
    status_word[STAT_WIND_LSB +: 8] = 8'(writemoveind);
    status_word[STAT_OCC_LSB +: 8]  = 8'(occ_cnt);
    status_word[STAT_DTR_BIT]       = buffer_dtr;
    status_word[STAT_OVF_BIT]       = overflow;
  end

`ifdef CMD_TIMEOUT_EN
  logic [31:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  // Command FSM: header decode, multi-word move sequencing and reply loading
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      ax             <= '0;
      drop           <= 1'b0;
      overflow       <= 1'b0;
      enable         <= '0;
      clock_divisor  <= 8'(CLK_DIV_RESET);
      word_send_data <= '0;
      writemoveind   <= '0;
      snap           <= '0;
`ifdef CMD_TIMEOUT_EN
      tmo_cnt        <= '0;
`endif
    end else if (word_received) begin
      word_send_data <= '0;
`ifdef CMD_TIMEOUT_EN
      tmo_cnt        <= '0;
`endif
      case (state)
        ST_IDLE: begin
          case (hdr)
            CMD_COORDINATED_STEP: begin
              snap  <= encoder_count;
              ax    <= '0;
              state <= ST_MV_DUR;
              if (slot_busy) begin
                drop     <= 1'b1;
                overflow <= 1'b1;
              end
            end
            CMD_MOTOR_ENABLE: enable <= word_data[NUM_AXES-1:0];
            CMD_CLK_DIVISOR:  clock_divisor <= word_data[7:0];
            CMD_API_VERSION: begin
              word_send_data <= {40'b0, VERSION_MAJOR, VERSION_MINOR, VERSION_PATCH};
              state          <= ST_VERSION;
            end
            CMD_STATUS: begin
              word_send_data <= status_word;
              overflow       <= 1'b0;
            end
            default: ;
          endcase
        end
        ST_MV_DUR: begin
          word_send_data <= snap[63:0];
          state          <= ST_MV_INC;
        end
        ST_MV_INC: state <= ST_MV_INCINC;
        ST_MV_INCINC: begin
          if (ax != LAST_AX) begin
            ax             <= ax + 3'd1;
            word_send_data <= snap[(int'(ax) + 1)*64 +: 64];
            state          <= ST_MV_INC;
          end else begin
            if (!drop) begin
              writemoveind <= writemoveind + 1'b1;
            end
            drop  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_VERSION: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
`ifdef CMD_TIMEOUT_EN
    else if (state != ST_IDLE) begin
      if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
        state    <= ST_IDLE;
        drop     <= 1'b0;
        overflow <= 1'b1;
        tmo_cnt  <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_spi_move_sequencer.sv
// Directed bench for spi_move_sequencer with two axes and a four-slot buffer.
// Latency: checks sample on the falling edge after each strobe's capturing edge.
// Backpressure: n/a.
module tb_spi_move_sequencer;

  localparam int NA  = 2;
  localparam int MBB = 2;

  logic          CLK = 1'b0;
  logic          resetn;
  logic          word_received;
  logic [63:0]   word_data;
  logic [63:0]   word_send_data;
  logic [3:0]    stepfinished;
  logic [3:0]    stepready;
  logic [1:0]    writemoveind;
  logic [63:0]   move_duration;
  logic [1:0]    rd_ind;
  logic [127:0]  increment;
  logic [127:0]  incrementincrement;
  logic [1:0]    dir;
  logic [127:0]  encoder_count;
  logic [1:0]    enable;
  logic [7:0]    clock_divisor;
  logic          buffer_dtr;
  logic          overflow;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  spi_move_sequencer #(
    .NUM_AXES         (NA),
    .MOVE_BUFFER_BITS (MBB),
    .CLK_DIV_RESET    (40),
    .TIMEOUT_CYCLES   (100)
  ) dut (
    .CLK                (CLK),
    .resetn             (resetn),
    .word_received      (word_received),
    .word_data          (word_data),
    .word_send_data     (word_send_data),
    .stepfinished       (stepfinished),
    .stepready          (stepready),
    .writemoveind       (writemoveind),
    .move_duration      (move_duration),
    .rd_ind             (rd_ind),
    .increment          (increment),
    .incrementincrement (incrementincrement),
    .dir                (dir),
    .encoder_count      (encoder_count),
    .enable             (enable),
    .clock_divisor      (clock_divisor),
    .buffer_dtr         (buffer_dtr),
    .overflow           (overflow)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe; returns on the falling edge after the capturing rising edge
  task automatic send_word(input logic [63:0] d);
    @(negedge CLK);
    word_received = 1'b1;
    word_data     = d;
    @(negedge CLK);
    word_received = 1'b0;
    word_data     = '0;
  endtask

  task automatic send_move(input logic [1:0] d, input logic [63:0] dur,
                           input logic [63:0] i0, input logic [63:0] ii0,
                           input logic [63:0] i1, input logic [63:0] ii1);
    send_word({8'h01, 54'b0, d});
    send_word(dur);
    send_word(i0);
    send_word(ii0);
    send_word(i1);
    send_word(ii1);
  endtask

  initial begin
    resetn        = 1'b0;
    word_received = 1'b0;
    word_data     = '0;
    stepfinished  = '0;
    rd_ind        = '0;
    encoder_count = {64'd2222, 64'd1111};
    repeat (3) @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);

    // Reset state
    check("rst_send", word_send_data, 0);
    check("rst_clkdiv", clock_divisor, 40);
    check("rst_stepready", stepready, 0);
    check("rst_enable", enable, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dtr", buffer_dtr, 1);
    check("rst_wind", writemoveind, 0);

    // First two-axis move with reply checks
    send_word({8'h01, 54'b0, 2'b10});
    check("hdr_reply", word_send_data, 0);
    send_word(64'd1000);
    check("dur_reply_enc0", word_send_data, 64'd1111);
    send_word(64'd5);
    check("inc0_reply", word_send_data, 0);
    send_word(64'd1);
    check("ii0_reply_enc1", word_send_data, 64'd2222);
    send_word(64'd7);
    send_word(64'd0);
    check("m1_stepready", stepready, 4'b0001);
    check("m1_wind", writemoveind, 1);
    check("m1_dir", dir, 2'b10);
    check("m1_inc", increment, {64'd7, 64'd5});
    check("m1_ii", incrementincrement, {64'd0, 64'd1});
    check("m1_dur", move_duration, 1000);

    // Fill remaining three slots; writemoveind wraps to 0
    send_move(2'b01, 64'd2000, 64'd11, 64'd12, 64'd13, 64'd14);
    send_move(2'b11, 64'd3000, 64'd21, 64'd22, 64'd23, 64'd24);
    send_move(2'b00, 64'd4000, 64'd31, 64'd32, 64'd33, 64'd34);
    check("full_stepready", stepready, 4'b1111);
    check("full_wind_wrap", writemoveind, 0);
    check("full_dtr", buffer_dtr, 0);
    rd_ind = 2'd2;
    #1;
    check("slot2_dur", move_duration, 3000);
    check("slot2_ii", incrementincrement, {64'd24, 64'd22});
    rd_ind = 2'd0;

    // Fifth move is dropped
    send_word({8'h01, 54'b0, 2'b11});
    check("drop_overflow", overflow, 1);
    send_word(64'd9999);
    send_word(64'd1);
    send_word(64'd2);
    send_word(64'd3);
    send_word(64'd4);
    check("drop_wind", writemoveind, 0);
    check("drop_stepready", stepready, 4'b1111);
    #1;
    check("drop_slot0_dur", move_duration, 1000);
    check("drop_slot0_dir", dir, 2'b10);

    // STATUS reports and clears overflow
    send_word({8'h0C, 56'b0});
    check("status1", word_send_data, 64'h2_0400);
    check("status_clr", overflow, 0);
    send_word({8'h0C, 56'b0});
    check("status2", word_send_data, 64'h0_0400);

    // DDA finishing slot 0 frees space combinationally
    @(negedge CLK);
    stepfinished = 4'b0001;
    #1;
    check("free_dtr", buffer_dtr, 1);

    // Enable, divisor, and an unknown header
    send_word({8'h0A, 54'b0, 2'b11});
    check("enable", enable, 2'b11);
    send_word({8'h0B, 48'b0, 8'h55});
    check("clkdiv", clock_divisor, 8'h55);
    send_word({8'h77, 56'hFF});
    check("unknown_clkdiv", clock_divisor, 8'h55);
    check("unknown_enable", enable, 2'b11);

    // API_VERSION consumes the following word
    send_word({8'hFE, 56'b0});
    check("version", word_send_data, 64'h0000_0000_0000_0301);
    send_word({8'h0B, 48'b0, 8'h22});
    check("version_consumed", clock_divisor, 8'h55);
    check("version_reply_zero", word_send_data, 0);
    send_word({8'h0B, 48'b0, 8'h22});
    check("post_version_hdr", clock_divisor, 8'h22);

    // Reset in the middle of a move discards it
    send_word({8'h01, 54'b0, 2'b01});
    send_word(64'd555);
    send_word(64'd66);
    stepfinished = 4'b0000;
    resetn = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    check("midrst_stepready", stepready, 0);
    check("midrst_clkdiv", clock_divisor, 40);
    check("midrst_wind", writemoveind, 0);
    send_word({8'h0B, 48'b0, 8'h33});
    check("midrst_idle_decode", clock_divisor, 8'h33);

`ifdef CMD_TIMEOUT_EN
    // Stall mid-move past the timeout
    send_word({8'h01, 54'b0, 2'b01});
    send_word(64'd50);
    repeat (105) @(negedge CLK);
    check("tmo_overflow", overflow, 1);
    send_word({8'h0B, 48'b0, 8'h44});
    check("tmo_next_hdr", clock_divisor, 8'h44);
    check("tmo_stepready", stepready, 0);
`else
    // Without the timeout, a long stall mid-move is harmless
    send_word({8'h01, 54'b0, 2'b01});
    send_word(64'd50);
    repeat (150) @(negedge CLK);
    check("stall_overflow", overflow, 0);
    send_word(64'd1);
    send_word(64'd2);
    send_word(64'd3);
    send_word(64'd4);
    check("stall_wind", writemoveind, 1);
    check("stall_stepready", stepready, 4'b0001);
    #1;
    check("stall_dur", move_duration, 50);
    check("stall_inc", increment, {64'd3, 64'd1});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
